// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler: state encoding, display word
// layout and the blanked/reset value of the display outputs.
package disp_pkg;

   localparam int unsigned NUM_W   = 16;
   localparam int unsigned DIGITS  = 4;
   localparam int unsigned MAX_SRC = 4;
   localparam int unsigned IDX_W   = 2;

   localparam logic [DIGITS-1:0] LES_BLANK = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_PIN  = 2'd2
   } state_e;

   typedef struct packed {
      logic [NUM_W-1:0]  num;
      logic [DIGITS-1:0] les;
      logic [DIGITS-1:0] points;
      logic [IDX_W-1:0]  cur;
      logic              tick;
   } disp_out_t;

   localparam disp_out_t OUT_RST = '{num: '0, les: LES_BLANK, points: '0, cur: '0, tick: 1'b0};

   function automatic logic [DIGITS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      return DIGITS'(1) << idx;
   endfunction

endpackage

// File: rtl/disp_scheduler_if.sv
// Bundle between the number producers, the scheduler and the disp_num driver.
interface disp_scheduler_if #(
   parameter int unsigned N_SRC = 4
) ();
   import disp_pkg::*;

   logic [NUM_W*N_SRC-1:0] src_num;
   logic [N_SRC-1:0]       src_valid;
   logic [N_SRC-1:0]       src_pin;
   logic                   freeze;
   logic [NUM_W-1:0]       num_out;
   logic [DIGITS-1:0]      les_out;
   logic [DIGITS-1:0]      points_out;
   logic [IDX_W-1:0]       cur_src;
   logic                   slot_tick;

   modport master (
      output src_num, src_valid, src_pin, freeze,
      input  num_out, les_out, points_out, cur_src, slot_tick
   );

   modport slave (
      input  src_num, src_valid, src_pin, freeze,
      output num_out, les_out, points_out, cur_src, slot_tick
   );

endinterface

// File: rtl/disp_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping modulo N.
module rr_pick
   import disp_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_start,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   localparam int unsigned POS_W = IDX_W + 1;

   logic [MAX_SRC-1:0] w_req;
   logic [POS_W-1:0]   w_pos;

   // Walk downwards so the candidate closest to i_start is the last (winning) write.
   always_comb begin
      w_req = MAX_SRC'(i_req);
      w_pos = '0;
      o_idx = '0;
      o_any = |i_req;
      for (int k = N - 1; k >= 0; k--) begin
         w_pos = {1'b0, i_start} + POS_W'(k);
         if (w_pos >= POS_W'(N)) begin
            w_pos = w_pos - POS_W'(N);
         end
         if (w_req[w_pos[IDX_W-1:0]]) begin
            o_idx = w_pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/disp_scheduler.sv
// Time-shares the 4-digit display between N_SRC producers: round-robin dwell,
// pin requests and a global freeze; all outputs registered.
module disp_scheduler
   import disp_pkg::*;
#(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned DWELL = 50_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   disp_scheduler_if.slave io_sched
);

   localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   disp_out_t        r_out, w_out_nxt;

   logic [N_SRC-1:0]   w_valid, w_pinned;
   logic [MAX_SRC-1:0] w_valid4;
   logic [NUM_W-1:0]   w_nums [MAX_SRC];
   logic [IDX_W-1:0]   w_first_idx, w_pin_idx, w_next_idx, w_start_next, w_sel;
   logic               w_any_valid, w_any_pin, w_any_next;
   logic               w_cur_valid, w_show, w_go_idle;

   assign w_valid      = io_sched.src_valid;
   assign w_pinned     = io_sched.src_pin & io_sched.src_valid;
   assign w_valid4     = MAX_SRC'(w_valid);
   assign w_cur_valid  = w_valid4[r_out.cur];
   assign w_start_next = r_out.cur + IDX_W'(1);

   for (genvar g = 0; g < MAX_SRC; g++) begin : g_num
      if (g < N_SRC) begin : g_src
         assign w_nums[g] = io_sched.src_num[NUM_W*g +: NUM_W];
      end else begin : g_pad
         assign w_nums[g] = '0;
      end
   end

   rr_pick #(.N(N_SRC)) u_first (
      .i_req   (w_valid),
      .i_start ('0),
      .o_idx   (w_first_idx),
      .o_any   (w_any_valid)
   );

   rr_pick #(.N(N_SRC)) u_pin (
      .i_req   (w_pinned),
      .i_start ('0),
      .o_idx   (w_pin_idx),
      .o_any   (w_any_pin)
   );

   rr_pick #(.N(N_SRC)) u_next (
      .i_req   (w_valid),
      .i_start (w_start_next),
      .o_idx   (w_next_idx),
      .o_any   (w_any_next)
   );

   // Next state; branch order encodes freeze > pin > valid-drop/release > dwell expiry.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_out_nxt      = r_out;
      w_out_nxt.tick = 1'b0;
      w_sel          = r_out.cur;
      w_show         = 1'b0;
      w_go_idle      = 1'b0;

      if (!io_sched.freeze) begin
         if (w_any_pin) begin
            w_state_nxt    = ST_PIN;
            w_cnt_nxt      = '0;
            w_sel          = w_pin_idx;
            w_show         = 1'b1;
            w_out_nxt.tick = (r_state == ST_IDLE) || (w_pin_idx != r_out.cur);
         end else if ((r_state == ST_PIN) || ((r_state == ST_SCAN) && !w_cur_valid)) begin
            w_cnt_nxt = '0;
            if (w_any_next) begin
               w_state_nxt    = ST_SCAN;
               w_sel          = w_next_idx;
               w_show         = 1'b1;
               w_out_nxt.tick = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
               w_go_idle   = 1'b1;
            end
         end else if (r_state == ST_SCAN) begin
            w_show = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt      = '0;
               w_sel          = w_next_idx;
               w_out_nxt.tick = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end else if (w_any_valid) begin
            w_state_nxt    = ST_SCAN;
            w_cnt_nxt      = '0;
            w_sel          = w_first_idx;
            w_show         = 1'b1;
            w_out_nxt.tick = 1'b1;
         end else begin
            w_go_idle = 1'b1;
         end

         if (w_show) begin
            w_out_nxt.cur    = w_sel;
            w_out_nxt.num    = w_nums[w_sel];
            w_out_nxt.les    = '0;
            w_out_nxt.points = idx_onehot(w_sel);
         end
         if (w_go_idle) begin
            w_out_nxt = OUT_RST;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_out   <= OUT_RST;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= w_out_nxt;
      end
   end

   assign io_sched.num_out    = r_out.num;
   assign io_sched.les_out    = r_out.les;
   assign io_sched.points_out = r_out.points;
   assign io_sched.cur_src    = r_out.cur;
   assign io_sched.slot_tick  = r_out.tick;

endmodule

// File: tb/tb_disp_scheduler.sv
// Scoreboard bench for disp_scheduler with DWELL=4, N_SRC=4: directed stimulus queues
// hand-derived expectations, a monitor pops and compares them after each rising edge.
module tb_disp_scheduler;
   import disp_pkg::*;

   localparam int unsigned N_SRC = 4;
   localparam int unsigned DWELL = 4;

   typedef struct {
      string       tag;
      logic [15:0] num;
      logic [3:0]  les;
      logic [3:0]  pts;
      logic [1:0]  cur;
      logic        tick;
      bit          tick_care;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q[$];
   logic [15:0] nums [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

   disp_scheduler_if #(.N_SRC(N_SRC)) sif ();

   disp_scheduler #(.N_SRC(N_SRC), .DWELL(DWELL)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io_sched (sif)
   );

   always #5 clk = ~clk;

   function automatic exp_t e_scan(string tag, int cur, bit tick, bit care = 1'b1);
      exp_t e;
      logic [3:0] one;
      one         = 4'b0001;
      e.tag       = tag;
      e.cur       = 2'(cur);
      e.num       = nums[cur];
      e.les       = 4'h0;
      e.pts       = 4'(one << cur);
      e.tick      = tick;
      e.tick_care = care;
      return e;
   endfunction

   function automatic exp_t e_idle(string tag, bit care = 1'b1);
      exp_t e;
      e.tag       = tag;
      e.cur       = 2'd0;
      e.num       = 16'h0000;
      e.les       = 4'hF;
      e.pts       = 4'h0;
      e.tick      = 1'b0;
      e.tick_care = care;
      return e;
   endfunction

   task automatic check_out(input exp_t e);
      n_checks++;
      if ({sif.num_out, sif.les_out, sif.points_out, sif.cur_src} !== {e.num, e.les, e.pts, e.cur}) begin
         n_fail++;
         $display("FAIL %s @%0t: got num=%h les=%h pts=%b cur=%0d, want num=%h les=%h pts=%b cur=%0d",
                  e.tag, $time, sif.num_out, sif.les_out, sif.points_out, sif.cur_src,
                  e.num, e.les, e.pts, e.cur);
      end
      if (e.tick_care) begin
         n_checks++;
         if (sif.slot_tick !== e.tick) begin
            n_fail++;
            $display("FAIL %s tick @%0t: got %b want %b", e.tag, $time, sif.slot_tick, e.tick);
         end
      end
   endtask

   task automatic step(input exp_t e);
      q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: outputs are presented every cycle, compare one queued expectation per edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            check_out(q.pop_front());
         end
      end
   end

   initial begin
      int order [4];
      order = '{0, 1, 3, 0};

      rst_n         = 1'b0;
      sif.src_num   = {nums[3], nums[2], nums[1], nums[0]};
      sif.src_valid = 4'b0000;
      sif.src_pin   = 4'b0000;
      sif.freeze    = 1'b0;
      repeat (2) @(negedge clk);
      check_out(e_idle("reset_values"));
      rst_n = 1'b1;
      repeat (2) step(e_idle("idle_no_valid"));

      // Rotation over 0,1,3 with source 2 invalid
      sif.src_valid = 4'b1011;
      for (int s = 0; s < 4; s++) begin
         step(e_scan("rot_enter", order[s], 1'b1));
         repeat (3) step(e_scan("rot_dwell", order[s], 1'b0));
      end

      // Pin source 1 while source 3 is on screen
      step(e_scan("rot_to1", 1, 1'b1));
      repeat (3) step(e_scan("rot_dwell1", 1, 1'b0));
      step(e_scan("rot_to3", 3, 1'b1));
      step(e_scan("dwell3", 3, 1'b0));
      sif.src_pin = 4'b0010;
      step(e_scan("pin_take", 1, 1'b1));
      repeat (8) step(e_scan("pin_hold", 1, 1'b0));
      sif.src_pin = 4'b0000;
      step(e_scan("pin_release", 3, 1'b1));

      // Valid drop on the displayed source, then drop everything
      repeat (3) step(e_scan("dwell3b", 3, 1'b0));
      step(e_scan("rot_to0", 0, 1'b1));
      repeat (3) step(e_scan("dwell0", 0, 1'b0));
      step(e_scan("rot_to1b", 1, 1'b1));
      step(e_scan("dwell1b", 1, 1'b0));
      sif.src_valid = 4'b1001;
      step(e_scan("drop_advance", 3, 1'b1));
      repeat (3) step(e_scan("drop_cnt_restart", 3, 1'b0));
      step(e_scan("drop_then_rot", 0, 1'b1));
      sif.src_valid = 4'b0000;
      step(e_idle("drop_all", 1'b0));
      step(e_idle("idle_after_drop"));

      // Freeze at counter=2 while the input number changes
      sif.src_valid = 4'b1011;
      step(e_scan("rescan", 0, 1'b1));
      repeat (2) step(e_scan("pre_freeze", 0, 1'b0));
      sif.freeze          = 1'b1;
      sif.src_num[15:0]   = 16'hAAAA;
      repeat (10) step(e_scan("freeze_hold", 0, 1'b0));
      sif.freeze          = 1'b0;
      sif.src_num[15:0]   = nums[0];
      step(e_scan("post_freeze_cnt3", 0, 1'b0));
      step(e_scan("post_freeze_rot", 1, 1'b1));

      // Pin asserted on the dwell-expiry cycle: no rotation
      repeat (3) step(e_scan("to_expiry", 1, 1'b0));
      sif.src_pin = 4'b0010;
      step(e_scan("pin_at_expiry", 1, 1'b0, 1'b0));
      repeat (4) step(e_scan("pin_expiry_hold", 1, 1'b0));
      sif.src_pin = 4'b0000;
      step(e_scan("pin_expiry_release", 3, 1'b1));
      step(e_scan("dwell3c", 3, 1'b0));

      // Asynchronous reset in mid-SCAN takes effect before the next edge
      #2 rst_n = 1'b0;
      #1 check_out(e_idle("async_reset"));
      sif.src_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(e_idle("post_reset_idle"));
      sif.src_valid = 4'b0001;
      step(e_scan("wake", 0, 1'b1));
      repeat (3) step(e_scan("single_dwell", 0, 1'b0));
      step(e_scan("single_src_tick", 0, 1'b1));
      step(e_scan("single_after_tick", 0, 1'b0));

      repeat (2) @(negedge clk);
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
